// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises and deglitches the pins, deframes
// device-to-host frames and emits one strobe per key event with E0/F0 folded into flags.
module ps2_keyboard #(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 7000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2Ck,
  input  logic       ps2D,
  output logic       kstb,
  output logic       make,
  output logic       ext,
  output logic [7:0] code
);

  localparam int unsigned TO_W  = 13;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SR_W  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  logic [1:0]        ck_sync;
  logic [1:0]        d_sync;
  logic              ck_s;
  logic              d_s;

  logic [FILTER-1:0] hist, hist_d;
  logic              filt, filt_d;
  logic              fall;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [SR_W-1:0]   sr, sr_d;
  logic [TO_W-1:0]   to_cnt, to_cnt_d;
  logic              brk, brk_d;
  logic              ex, ex_d;
  logic              kstb_d;
  logic              make_d;
  logic              ext_d;
  logic [7:0]        code_d;

  logic [7:0]        rx_byte;
  logic              frame_ok;

  assign ck_s     = ck_sync[1];
  assign d_s      = d_sync[1];
  assign rx_byte  = sr[7:0];
  assign frame_ok = (^sr[8:0]) & sr[9];

  // Two-flop synchronisers for both pins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_sync <= 2'b11;
      d_sync  <= 2'b11;
    end else begin
      ck_sync <= {ck_sync[0], ps2Ck};
      d_sync  <= {d_sync[0], ps2D};
    end
  end

  // Glitch filter: the filtered clock only moves once the whole history agrees.
  always_comb begin
    hist_d = hist;
    filt_d = filt;
    fall   = 1'b0;
    if (ce) begin
      hist_d = {hist[FILTER-2:0], ck_s};
      if (&hist) begin
        filt_d = 1'b1;
      end else if (~|hist) begin
        filt_d = 1'b0;
      end
      fall = filt & ~filt_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist <= '1;
      filt <= 1'b1;
    end else begin
      hist <= hist_d;
      filt <= filt_d;
    end
  end

  // Frame state machine, timeout and byte interpretation.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    sr_d     = sr;
    to_cnt_d = to_cnt;
    brk_d    = brk;
    ex_d     = ex;
    kstb_d   = 1'b0;
    make_d   = make;
    ext_d    = ext;
    code_d   = code;
    if (ce) begin
      unique case (state)
        IDLE: begin
          if (fall && !d_s) begin
            state_d  = SHIFT;
            cnt_d    = '0;
            to_cnt_d = '0;
          end
        end
        SHIFT: begin
          if (fall) begin
            sr_d     = {d_s, sr[SR_W-1:1]};
            to_cnt_d = '0;
            if (cnt == CNT_W'(9)) begin
              state_d = CHECK;
            end else begin
              cnt_d = cnt + CNT_W'(1);
            end
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            state_d  = IDLE;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt + TO_W'(1);
          end
        end
        CHECK: begin
          state_d = IDLE;
          if (frame_ok) begin
            unique case (rx_byte)
              8'hF0: brk_d = 1'b1;
              8'hE0: ex_d  = 1'b1;
              8'hE1, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'h00, 8'hFF: ;
              default: begin
                kstb_d = 1'b1;
                code_d = rx_byte;
                make_d = ~brk;
                ext_d  = ex;
                brk_d  = 1'b0;
                ex_d   = 1'b0;
              end
            endcase
          end else begin
            brk_d = 1'b0;
            ex_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      sr     <= '0;
      to_cnt <= '0;
      brk    <= 1'b0;
      ex     <= 1'b0;
      kstb   <= 1'b0;
      make   <= 1'b0;
      ext    <= 1'b0;
      code   <= 8'h00;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      sr     <= sr_d;
      to_cnt <= to_cnt_d;
      brk    <= brk_d;
      ex     <= ex_d;
      kstb   <= kstb_d;
      make   <= make_d;
      ext    <= ext_d;
      code   <= code_d;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Randomised bench for ps2_keyboard: a byte-level key-event model predicts every strobe.
`timescale 1ns/1ps
module tb_ps2_keyboard;

  localparam int HALF    = 16;   // PS/2 half period in ce samples
  localparam int TO_SIM  = 300;  // reduced timeout to keep the run short
  localparam int IDLE_TO = 400;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ce    = 1'b0;
  logic       ps2Ck = 1'b1;
  logic       ps2D  = 1'b1;
  logic       kstb;
  logic       make;
  logic       ext;
  logic [7:0] code;

  int vectors    = 0;
  int miscompares = 0;
  bit checking   = 1'b0;

  typedef struct packed {
    logic [7:0] code;
    logic       make;
    logic       ext;
  } ev_t;

  ev_t exp_q[$];
  ev_t held;
  bit  m_brk, m_ex;
  bit  prev_kstb;

  ps2_keyboard #(.FILTER(8), .TIMEOUT(TO_SIM)) dut (
    .clock(clock), .reset(reset), .ce(ce), .ps2Ck(ps2Ck), .ps2D(ps2D),
    .kstb(kstb), .make(make), .ext(ext), .code(code)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    #1 ce = ~ce;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_ce(input int n);
    tick(2 * n);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Key-event model at byte granularity.
  task automatic model_byte(input logic [7:0] b, input bit valid);
    if (!valid) begin
      m_brk = 1'b0;
      m_ex  = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ex = 1'b1;
    end else if (!(b inside {8'hE1, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'h00, 8'hFF})) begin
      exp_q.push_back('{code: b, make: !m_brk, ext: m_ex});
      m_brk = 1'b0;
      m_ex  = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    m_brk = 1'b0;
    m_ex  = 1'b0;
    held  = '0;
    tick(3);
    reset = 1'b1;
  endtask

  // Drives nbits of an 11-bit frame; optional glitch in the high phase or reset in the low phase.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit, input int rst_bit);
    logic [10:0] f;
    f = {~bad_stop, (bad_par ? ^b : ~^b), b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2D = f[i];
      if (i == glitch_bit) begin
        wait_ce(4); ps2Ck = 1'b0; wait_ce(3); ps2Ck = 1'b1; wait_ce(HALF - 7);
      end else begin
        wait_ce(HALF);
      end
      ps2Ck = 1'b0;
      if (i == rst_bit) begin
        wait_ce(2); do_reset(); wait_ce(HALF - 4);
      end else begin
        wait_ce(HALF);
      end
      ps2Ck = 1'b1;
    end
    ps2D = 1'b1;
    wait_ce(HALF);
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    model_byte(b, !bad_par && !bad_stop);
    send_frame(b, bad_par, bad_stop, 11, -1, -1);
  endtask

  task automatic settle();
    wait_ce(40);
    check("pending_events", 32'(exp_q.size()), 32'd0);
  endtask

  // Per-cycle comparison of strobe and held outputs against the model.
  always @(negedge clock) begin
    if (checking) begin
      if (kstb) begin
        check("strobe_width", 32'(prev_kstb), 32'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_strobe: got code %0h make %0b ext %0b, expected no strobe", code, make, ext);
        end else begin
          held = exp_q.pop_front();
          check("strobe_code", 32'(code), 32'(held.code));
          check("strobe_make", 32'(make), 32'(held.make));
          check("strobe_ext",  32'(ext),  32'(held.ext));
        end
      end else begin
        check("hold_code", 32'(code), 32'(held.code));
        check("hold_make", 32'(make), 32'(held.make));
        check("hold_ext",  32'(ext),  32'(held.ext));
      end
      prev_kstb = kstb;
    end
  end

  initial begin
    logic [7:0] b;
    int r;
    held = '0;
    m_brk = 1'b0;
    m_ex = 1'b0;
    prev_kstb = 1'b0;
    tick(4);
    checking = 1'b1;
    tick(4);
    check("reset_kstb", 32'(kstb), 32'd0);
    check("reset_code", 32'(code), 32'h00);
    reset = 1'b1;
    wait_ce(20);

    // Plain make.
    frame(8'h1C, 0, 0); settle();
    check("lit_make_code", 32'(code), 32'h1C);
    check("lit_make_make", 32'(make), 32'd1);
    check("lit_make_ext",  32'(ext),  32'd0);

    // Break, extended break, plain make.
    frame(8'hF0, 0, 0); frame(8'h1C, 0, 0); settle();
    check("lit_brk_make", 32'(make), 32'd0);
    frame(8'hE0, 0, 0); frame(8'hF0, 0, 0); frame(8'h75, 0, 0); settle();
    check("lit_ebrk_code", 32'(code), 32'h75);
    check("lit_ebrk_make", 32'(make), 32'd0);
    check("lit_ebrk_ext",  32'(ext),  32'd1);
    frame(8'h1C, 0, 0); settle();
    check("lit_after_ext", 32'(ext), 32'd0);

    // Bad parity clears flags.
    frame(8'hE0, 0, 0); frame(8'h1C, 1, 0); frame(8'h1C, 0, 0); settle();
    check("lit_par_ext",  32'(ext),  32'd0);
    check("lit_par_make", 32'(make), 32'd1);

    // Timeout on a partial frame.
    send_frame(8'h55, 0, 0, 5, -1, -1);
    wait_ce(IDLE_TO);
    frame(8'h29, 0, 0); settle();
    check("lit_to_code", 32'(code), 32'h29);

    // Glitch rejection, idle then mid-frame.
    ps2D = 1'b0; ps2Ck = 1'b0; wait_ce(3); ps2Ck = 1'b1; ps2D = 1'b1; wait_ce(HALF);
    model_byte(8'h3A, 1);
    send_frame(8'h3A, 0, 0, 11, 4, -1); settle();
    check("lit_glitch_code", 32'(code), 32'h3A);

    // Reset during data bit 5, then a clean frame after the garbage times out.
    send_frame(8'h1C, 0, 0, 11, -1, 6);
    wait_ce(IDLE_TO);
    check("lit_rst_code", 32'(code), 32'h00);
    check("lit_rst_make", 32'(make), 32'd0);
    frame(8'h1C, 0, 0); settle();
    check("lit_rst_after", 32'(code), 32'h1C);

    // Randomised traffic.
    for (int n = 0; n < 20; n++) begin
      r = int'($urandom_range(0, 9));
      b = 8'($urandom);
      case (r)
        0: frame(8'hF0, 0, 0);
        1: frame(8'hE0, 0, 0);
        2: frame((b[0] ? 8'hFA : 8'hAA), 0, 0);
        3: frame(b, 1, 0);
        4: frame(b, 0, 1);
        default: frame(b, 0, 0);
      endcase
    end
    settle();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard receiver that produces the scan-code strobe interface consumed by the machine top level: `kstb`, `make` and `code`. It samples the keyboard's open-collector clock and data lines and removes glitches. It deframes 11-bit device-to-host frames and folds the `E0`/`F0` prefixes into flags. Each complete key event is emitted as a single-cycle strobe. It sits between the board's PS/2 pins and the top-level keyboard inputs, running from the 56 MHz system clock with a 7 MHz enable.

## Interface
- `FILTER`, 8: number of consecutive identical `ce` samples required before the filtered PS/2 clock changes level.
- `TIMEOUT`, 7000: `ce` cycles (about 1 ms at 7 MHz) without a filtered falling edge after which a partial frame is abandoned.
- `clock`  in  1  system clock, 56 MHz, all logic on posedge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `ce`  in  1  sample enable, one `clock` cycle wide, 7 MHz.
- `ps2Ck`  in  1  raw PS/2 clock pin.
- `ps2D`  in  1  raw PS/2 data pin.
- `kstb`  out  1  key event strobe, high for exactly one `clock` cycle.
- `make`  out  1  1 = key press, 0 = key release (`F0` seen).
- `ext`  out  1  1 = extended key (`E0` seen).
- `code`  out  8  scan code, excluding prefixes.

## Operation
- **Synchroniser.** `ps2Ck` and `ps2D` each pass through 2 flops clocked on `clock`.
- **Glitch filter.**
  - On each `ce`, the synchronised clock is shifted into a `FILTER`-bit history register.
  - The filtered clock goes to 1 when the history is all ones and to 0 when it is all zeros; otherwise it holds.
  - A falling edge is the filtered clock going 1→0. Data is sampled from the synchronised `ps2D` on that `ce`.
- **Frame state machine, states IDLE / SHIFT / CHECK.**
  - IDLE: a falling edge with data 0 (start bit) moves to SHIFT with bit count 0. A falling edge with data 1 is ignored and the state stays IDLE.
  - SHIFT: each falling edge shifts one data bit in LSB first; count 0..7 are data, 8 is parity, 9 is stop. After the stop bit, move to CHECK.
  - CHECK (one `ce`): the frame is valid if the 8 data bits plus the parity bit hold an odd number of ones and stop = 1. Always return to IDLE.
  - Invalid frame: it is discarded and the `brk` and `ex` flags are cleared. There is no strobe.
- **Timeout.**
  - A 13-bit counter clears on every falling edge and increments on `ce` while in SHIFT.
  - Reaching `TIMEOUT` forces IDLE with the partial frame discarded; the flags are unchanged.
- **Byte handling in CHECK, valid frame only.**
  - `F0`: set `brk`; no strobe.
  - `E0`: set `ex`; no strobe.
  - `E1`, `AA`, `EE`, `FA`, `FE`, `00`, `FF`: ignored, with no strobe and no flag change.
  - Any other byte: `code` ← byte, `make` ← !`brk`, `ext` ← `ex`, then `kstb` pulses and `brk`/`ex` are cleared.
- **Output hold.** `code`, `make` and `ext` keep their values until the next strobe.
- **Reset values.** `kstb` = 0, `make` = 0, `ext` = 0, `code` = 8'h00. Internally: state IDLE, flags 0, filter history all ones, filtered clock 1.

## Timing
- **Filter latency.** A pin edge becomes a filtered edge after 2 `clock` cycles of synchronisation plus `FILTER` `ce` samples, about 1.2 µs at the defaults. The PS/2 half-period is at least 30 µs, so the margin is ample.
- **Strobe timing.**
  - The frame is evaluated on the `ce` following the stop-bit falling edge (CHECK).
  - `kstb`, `code`, `make` and `ext` are registered together and become valid at that `clock` edge.
  - `kstb` drops on the next `clock` edge and never lasts longer than 1 cycle.
- **`ce` gating.** When `ce` is low, no state advances and no sample is taken.
- **Back-to-back frames.** These need no idle gap beyond the stop bit: CHECK completes before the next start-bit edge, which is at least 30 µs later.
- **Reset mid-frame.** Reset deasserted during a frame leaves the state machine in IDLE, so the remaining bits are ignored until a start-bit edge. Any garbage frame that follows is caught by the parity, stop-bit or timeout checks.

## Test plan
- **Plain make.** Frame `1C` (A key) at 12.5 kHz → exactly one 1-cycle `kstb` with `code` = 1C, `make` = 1, `ext` = 0.
- **Break, extended break, then plain make.** Frames `F0`, `1C` → a single strobe with `code` = 1C, `make` = 0. Then `E0`, `F0`, `75` → a single strobe with `code` = 75, `make` = 0, `ext` = 1. A following `1C` → `make` = 1, `ext` = 0.
- **Bad parity clears flags.** `E0`, then a `1C` frame with bad parity → no strobe. A following good `1C` → `ext` = 0, `make` = 1.
- **Timeout.** A start bit plus 4 data bits, then idle for 8000 `ce` cycles, then a full `29` frame → one strobe with `code` = 29. No spurious strobe.
- **Glitch rejection.** A 3-`ce`-wide low pulse on `ps2Ck` while in IDLE, and one mid-frame → no bit shifted. The frame in progress still decodes correctly.
- **Reset mid-frame.** Assert `reset` low during bit 5, release, then send `1C` → the outputs read their reset values until one strobe with `code` = 1C.
